mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single byte-addressable memory port between the instruction-fetch requester and the load/store data requester.
- Accepts one request per cycle through a valid/ready handshake and drives the memory's write enable, size code, address and write data.
- Registers read data with RISC-V sign/zero extension and returns a one-cycle-latency response to the granted requester.
- Rejects misaligned and illegal-size accesses without touching memory.

Parameters:
AWIDTH, 32, address width, identical to the memory's address width
DWIDTH, 32, data port width (fixed 32; RV32)
MAX_DATA_BURST, 4, consecutive contended data grants allowed before fetch is forced through

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
if_req_valid  input  1  fetch request (always word read)
if_req_ready  output  1  fetch request accepted this cycle
if_addr  input  AWIDTH  fetch byte address
if_rsp_valid  output  1  fetch response valid (single-cycle pulse)
if_rsp_data  output  DWIDTH  fetched word
if_rsp_err  output  1  fetch misaligned (addr[1:0]!=0)
d_req_valid  input  1  data request
d_req_ready  output  1  data request accepted this cycle
d_we  input  1  1=store, 0=load
d_funct3  input  3  RV32 funct3: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
d_addr  input  AWIDTH  data byte address
d_wdata  input  DWIDTH  store data, LSB-aligned
d_rsp_valid  output  1  data response valid (single-cycle pulse)
d_rsp_data  output  DWIDTH  extended load data; 0 for stores and errors
d_rsp_err  output  1  misaligned or illegal funct3
mem_wr  output  1  memory write enable
mem_size  output  2  memory size code: 0 byte, 1 half, 2 word
mem_addr  output  AWIDTH  memory address
mem_wdata  output  DWIDTH  memory write data
mem_rdata  input  DWIDTH  memory read data, combinational from mem_addr

Behaviour:
Reset:
- While rst=1: both ready outputs = 0; mem_wr = 0.
- Registered outputs (rsp_valid, rsp_data, rsp_err, streak counter) are cleared to 0 at the first posedge with rst high.
- Requests pending when reset asserts are dropped. Their responses are never issued.

Arbitration (combinational, per cycle):
- Only one requester valid: that requester is granted.
- Both valid: data wins, unless streak == MAX_DATA_BURST, in which case fetch wins.
- streak update:
  - +1 when data is granted while if_req_valid=1.
  - Reset to 0 when fetch is granted or when if_req_valid=0.
  - Saturates at MAX_DATA_BURST.
- Granted requester sees ready=1 in the same cycle. The loser sees ready=0 and must hold its request stable.
- Every valid request is granted, including error requests; errors consume a slot.

Memory drive:
- Memory is driven only for legal accesses, only in the grant cycle.
- mem_addr, mem_size and mem_wdata come from the granted request. When idle they are 0.
- mem_wr = grant_data & d_we & legal. The write commits at the posedge that ends the grant cycle.
- Legal conditions:
  - size byte: any address.
  - size half: addr[0]=0.
  - size word: addr[1:0]=0.
  - funct3 3, 6, 7 are illegal for loads.
  - funct3 >= 3 is illegal for stores.

Response (latency 1):
- A request granted in cycle T produces rsp_valid=1 in cycle T+1 only, on the granted side.
- Load data is sampled from mem_rdata at the end of cycle T:
  - LB: sign-extend [7:0].
  - LBU: zero-extend [7:0].
  - LH: sign-extend [15:0].
  - LHU: zero-extend [15:0].
  - LW: full word.
- Store response: data 0, err 0 (write acknowledge).
- Error response: err=1, data 0, memory untouched.
- There is no response backpressure. Requesters must accept the response in T+1.

Throughput and boundaries:
- Back-to-back grants every cycle are allowed.
- Store at T followed by load of the same address at T+1 returns the new data, because the write committed at the T/T+1 edge.
- Address arithmetic at the top of the address space (addr+3 wrap) is the memory's concern. The arbiter passes the address unchanged.
- rst asserted in cycle T+1 suppresses the response due in T+1.

Decomposition:
- Shared package holds:
  - funct3 constants: F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - Size codes: SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
- One sub-module, load_extend: combinational funct3 + raw word -> extended word, reusable by the pipeline writeback.
- Arbitration, streak counter and response registers stay in the top module.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 next cycle -> d_rsp_data=0xDEADBEEF at T+2, mem_wr high exactly one cycle.
- Memory word 0x000080F0 at 0x20: LB 0x20 -> 0xFFFFFFF0; LBU -> 0x000000F0; LH -> 0xFFFF80F0; LHU -> 0x000080F0.
- LH 0x21 and SW 0x22 -> d_rsp_err=1, data 0, mem_wr never asserted, memory word unchanged.
- Both valid continuously, MAX_DATA_BURST=4 -> grant pattern D,D,D,D,F repeating; fetch never waits more than 4 cycles.
- Fetch 0x3 -> if_rsp_err=1 at T+1; fetch 0x4 alone -> if_req_ready same cycle, if_rsp_valid next cycle.
- rst pulsed the cycle after an accepted load -> no d_rsp_valid; all outputs 0 the cycle after reset.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared funct3 codes, memory size codes and access-legality
//                helpers for the memory port arbiter and load extension.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    function automatic mem_size_e f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'd1:    return SZ_HALF;
            2'd2:    return SZ_WORD;
            default: return SZ_BYTE;
        endcase
    endfunction

    // Unsigned variants exist only for loads; stores are limited to B/H/W.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3,
                                      input logic [1:0] lsb);
        case (f3)
            F3_B:    return 1'b1;
            F3_BU:   return ~we;
            F3_H:    return ~lsb[0];
            F3_HU:   return ~we & ~lsb[0];
            F3_W:    return (lsb == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_load_extend.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_load_extend
//  Description : Combinational RV32 load sign/zero extension of a raw word.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter_load_extend
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (funct3)
            F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
            F3_BU:   ext = {24'd0, raw[7:0]};
            F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
            F3_HU:   ext = {16'd0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one byte-addressable memory port between instruction
//                fetch and load/store, with one-cycle registered responses.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AWIDTH         = 32,
    parameter int DWIDTH         = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [AWIDTH-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DWIDTH-1:0] if_rsp_data,
    output logic              if_rsp_err,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [DWIDTH-1:0] d_wdata,
    output logic              d_rsp_valid,
    output logic [DWIDTH-1:0] d_rsp_data,
    output logic              d_rsp_err,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);

    localparam int c_STREAK_W = $clog2(MAX_DATA_BURST + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_DATA_BURST);

    logic [c_STREAK_W-1:0] r_streak;
    logic                  w_grant_if;
    logic                  w_grant_d;
    logic                  w_if_misal;
    logic                  w_d_legal;
    mem_size_e             w_d_size;
    logic [DWIDTH-1:0]     w_ext;

    logic                  r_if_rsp_valid;
    logic [DWIDTH-1:0]     r_if_rsp_data;
    logic                  r_if_rsp_err;
    logic                  r_d_rsp_valid;
    logic [DWIDTH-1:0]     r_d_rsp_data;
    logic                  r_d_rsp_err;

    // Data normally has priority; an exhausted streak lets fetch through.
    assign w_grant_d  = ~rst & d_req_valid & ~(if_req_valid & (r_streak == c_STREAK_MAX));
    assign w_grant_if = ~rst & if_req_valid & ~w_grant_d;

    assign if_req_ready = w_grant_if;
    assign d_req_ready  = w_grant_d;

    assign w_if_misal = (if_addr[1:0] != 2'b00);
    assign w_d_legal  = f3_legal(d_we, d_funct3, d_addr[1:0]);
    assign w_d_size   = f3_size(d_funct3);

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = SZ_BYTE;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_grant_if && !w_if_misal) begin
            mem_size = SZ_WORD;
            mem_addr = if_addr;
        end else if (w_grant_d && w_d_legal) begin
            mem_wr    = d_we;
            mem_size  = w_d_size;
            mem_addr  = d_addr;
            mem_wdata = d_we ? d_wdata : '0;
        end
    end

    mem_port_arbiter_load_extend u_load_extend (
        .funct3 (d_funct3),
        .raw    (mem_rdata),
        .ext    (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak <= '0;
        end else if (w_grant_d && if_req_valid) begin
            if (r_streak != c_STREAK_MAX) begin
                r_streak <= r_streak + 1'b1;
            end
        end else begin
            r_streak <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_rsp_valid <= 1'b0;
            r_if_rsp_data  <= '0;
            r_if_rsp_err   <= 1'b0;
            r_d_rsp_valid  <= 1'b0;
            r_d_rsp_data   <= '0;
            r_d_rsp_err    <= 1'b0;
        end else begin
            r_if_rsp_valid <= w_grant_if;
            r_if_rsp_err   <= w_grant_if & w_if_misal;
            r_if_rsp_data  <= (w_grant_if && !w_if_misal) ? mem_rdata : '0;
            r_d_rsp_valid  <= w_grant_d;
            r_d_rsp_err    <= w_grant_d & ~w_d_legal;
            r_d_rsp_data   <= (w_grant_d && w_d_legal && !d_we) ? w_ext : '0;
        end
    end

    // Reset in the response cycle suppresses the response already registered.
    assign if_rsp_valid = r_if_rsp_valid & ~rst;
    assign if_rsp_err   = r_if_rsp_err & ~rst;
    assign if_rsp_data  = rst ? '0 : r_if_rsp_data;
    assign d_rsp_valid  = r_d_rsp_valid & ~rst;
    assign d_rsp_err    = r_d_rsp_err & ~rst;
    assign d_rsp_data   = rst ? '0 : r_d_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Scoreboard bench for mem_port_arbiter with a byte memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [31:0] if_addr, if_rsp_data;
    logic        d_req_valid, d_req_ready, d_we, d_rsp_valid, d_rsp_err;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr, d_wdata, d_rsp_data;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q_if[$];
    exp_t q_d[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   wr_cnt = 0;
    logic [7:0] mem [0:255];

    mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .MAX_DATA_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
        .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mword(input logic [7:0] a);
        return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endfunction

    assign mem_rdata = mword(mem_addr[7:0]);

    // Little-endian byte memory; LSB-aligned write data.
    always @(posedge clk) begin
        if (mem_wr === 1'b1) begin
            mem[mem_addr[7:0]] <= mem_wdata[7:0];
            if (mem_size != 2'd0) mem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
            if (mem_size == 2'd2) begin
                mem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
                mem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    always @(negedge clk) if (mem_wr === 1'b1) wr_cnt <= wr_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Monitor: pops and compares whenever a response is presented.
    always @(negedge clk) begin
        exp_t e;
        if (if_rsp_valid === 1'b1) begin
            if (q_if.size() == 0) chk("if_rsp_unexpected", 32'd1, 32'd0);
            else begin
                e = q_if.pop_front();
                chk("if_rsp_data", if_rsp_data, e.data);
                chk("if_rsp_err", {31'd0, if_rsp_err}, {31'd0, e.err});
                chk("if_rsp_latency", cyc, e.cyc);
            end
        end
        if (d_rsp_valid === 1'b1) begin
            if (q_d.size() == 0) chk("d_rsp_unexpected", 32'd1, 32'd0);
            else begin
                e = q_d.pop_front();
                chk("d_rsp_data", d_rsp_data, e.data);
                chk("d_rsp_err", {31'd0, d_rsp_err}, {31'd0, e.err});
                chk("d_rsp_latency", cyc, e.cyc);
            end
        end
    end

    task automatic data_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                            input bit push);
        bit acc = 1'b0;
        @(posedge clk); #1;
        d_req_valid = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            if (d_req_ready === 1'b1) begin
                acc = 1'b1;
                if (push) q_d.push_back(exp_t'{ed, ee, cyc + 1});
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!acc) chk("d_req_timeout", 32'd0, 32'd1);
    endtask

    task automatic fetch_req(input logic [31:0] a, input logic [31:0] ed, input logic ee,
                             output bit first);
        bit acc = 1'b0;
        first = 1'b0;
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_addr = a;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            if (if_req_ready === 1'b1) begin
                acc   = 1'b1;
                first = (k == 0);
                q_if.push_back(exp_t'{ed, ee, cyc + 1});
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!acc) chk("if_req_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit first;
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        mem[8'h20] <= 8'hF0; mem[8'h21] <= 8'h80;
        mem[8'h04] <= 8'h13; mem[8'h05] <= 8'h05;
        rst = 1'b1;
        if_req_valid = 1'b1; if_addr = 32'h4;
        d_req_valid = 1'b1; d_we = 1'b1; d_funct3 = 3'd2; d_addr = 32'h20; d_wdata = 32'h1;

        // Reset: requests must be ignored
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_if_ready", {31'd0, if_req_ready}, 32'd0);
        chk("rst_d_ready", {31'd0, d_req_ready}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; if_req_valid = 1'b0; d_req_valid = 1'b0;
        @(negedge clk);
        chk("rst_if_rsp_valid", {31'd0, if_rsp_valid}, 32'd0);
        chk("rst_d_rsp_valid", {31'd0, d_rsp_valid}, 32'd0);
        chk("rst_d_rsp_data", d_rsp_data, 32'd0);

        // Store then load back-to-back
        data_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        data_req(1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        idle(2);
        chk("sw_mem_wr_cycles", wr_cnt, 32'd1);

        // Extension of 0x000080F0
        data_req(1'b0, 3'd0, 32'h20, 32'h0, 32'hFFFFFFF0, 1'b0, 1'b1);
        data_req(1'b0, 3'd4, 32'h20, 32'h0, 32'h000000F0, 1'b0, 1'b1);
        data_req(1'b0, 3'd1, 32'h20, 32'h0, 32'hFFFF80F0, 1'b0, 1'b1);
        data_req(1'b0, 3'd5, 32'h20, 32'h0, 32'h000080F0, 1'b0, 1'b1);
        data_req(1'b0, 3'd2, 32'h20, 32'h0, 32'h000080F0, 1'b0, 1'b1);
        data_req(1'b0, 3'd1, 32'h21, 32'h0, 32'h0, 1'b1, 1'b1);

        // Error accesses: misaligned, illegal funct3
        data_req(1'b1, 3'd2, 32'h22, 32'hCAFEF00D, 32'h0, 1'b1, 1'b1);
        data_req(1'b1, 3'd4, 32'h20, 32'h12345678, 32'h0, 1'b1, 1'b1);
        data_req(1'b0, 3'd3, 32'h20, 32'h0, 32'h0, 1'b1, 1'b1);
        data_req(1'b1, 3'd1, 32'h23, 32'hAAAA5555, 32'h0, 1'b1, 1'b1);
        idle(2);
        chk("err_mem_wr_cycles", wr_cnt, 32'd1);
        chk("err_word_20", mword(8'h20), 32'h000080F0);
        chk("err_word_24", mword(8'h24), 32'h00000000);

        // Fetch: misaligned, then aligned alone
        fetch_req(32'h3, 32'h0, 1'b1, first);
        fetch_req(32'h4, 32'h00000513, 1'b0, first);
        chk("if_ready_same_cycle", {31'd0, first}, 32'd1);
        idle(2);

        // Contention: both valid for 15 cycles -> D,D,D,D,F repeating
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_addr = 32'h4;
        d_req_valid = 1'b1; d_we = 1'b0; d_funct3 = 3'd2; d_addr = 32'h20;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("arb_onehot", {31'd0, d_req_ready} + {31'd0, if_req_ready}, 32'd1);
            chk("arb_grant_data", {31'd0, d_req_ready}, (i % 5 == 4) ? 32'd0 : 32'd1);
            if (d_req_ready === 1'b1) begin
                q_d.push_back(exp_t'{32'h000080F0, 1'b0, cyc + 1});
                chk("arb_mem_addr_d", mem_addr, 32'h20);
            end
            if (if_req_ready === 1'b1) begin
                q_if.push_back(exp_t'{32'h00000513, 1'b0, cyc + 1});
                chk("arb_mem_addr_if", mem_addr, 32'h4);
            end
            @(posedge clk); #1;
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        idle(2);

        // Reset the cycle after an accepted load: response is dropped
        data_req(1'b0, 3'd2, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; d_req_valid = 1'b0;
        @(negedge clk);
        chk("rst_drop_d_rsp_valid", {31'd0, d_rsp_valid}, 32'd0);
        chk("rst_drop_mem_wr", {31'd0, mem_wr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_d_rsp_valid", {31'd0, d_rsp_valid}, 32'd0);
        chk("post_rst_d_rsp_data", d_rsp_data, 32'd0);
        chk("post_rst_d_rsp_err", {31'd0, d_rsp_err}, 32'd0);
        chk("post_rst_if_rsp_valid", {31'd0, if_rsp_valid}, 32'd0);
        chk("post_rst_if_rsp_data", if_rsp_data, 32'd0);
        chk("post_rst_mem_addr", mem_addr, 32'd0);
        chk("post_rst_readies", {30'd0, if_req_ready, d_req_ready}, 32'd0);

        idle(3);
        chk("q_if_drained", q_if.size(), 32'd0);
        chk("q_d_drained", q_d.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
